// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// counter-width helpers.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Bit count needed to hold WIDTH-1 (the iteration counter start value).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift in a dividend bit, then subtract
// the divisor when it fits.
module div_iter_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_ext;

    always_comb begin
        shifted = {rem_in[WIDTH-1:0], bit_in};
        dvs_ext = {1'b0, divisor};
        q_bit   = (shifted >= dvs_ext);
        rem_out = q_bit ? (shifted - dvs_ext) : shifted;
    end

endmodule

// File: rtl/div_seq_nbit.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on
// both sides. Define DIV_SIGNED_EN for two's-complement operands (adds FIXUP).
module div_seq_nbit
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d, step_rem;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             dz_q, dz_d;
    logic             step_q;
`ifdef DIV_SIGNED_EN
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
`endif

    // acc_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (acc_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef DIV_SIGNED_EN
                    acc_d  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
                    dvs_d  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
                    negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    negr_d = dividend[WIDTH-1];
`else
                    acc_d  = dividend;
                    dvs_d  = divisor;
`endif
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    zero_d  = (divisor == '0);
                    state_d = CALC;
                end
            end
            CALC: begin
                // A zero divisor spends one cycle here so its result lands after edge 1.
                if (zero_q) begin
                    quot_d  = '0;
                    rmd_d   = '0;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = step_rem;
                    acc_d = {acc_q[WIDTH-2:0], step_q};
                    if (cnt_q == '0) begin
                        dz_d = 1'b0;
`ifdef DIV_SIGNED_EN
                        state_d = FIXUP;
`else
                        quot_d  = {acc_q[WIDTH-2:0], step_q};
                        rmd_d   = step_rem[WIDTH-1:0];
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
`ifdef DIV_SIGNED_EN
            FIXUP: begin
                // MIN/-1 wraps naturally: magnitude MIN with no negation.
                quot_d  = negq_q ? (~acc_q + 1'b1) : acc_q;
                rmd_d   = negr_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq_nbit.sv
// Directed, table-driven bench for div_seq_nbit (WIDTH=8), plus hand-written
// sequences for backpressure, mid-operation reset and back-to-back operation.
module tb_div_seq_nbit;

    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk, rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         div_zero, busy;

    int n_chk, n_err;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    div_seq_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Waits for in_ready, presents operands for one edge, then scrambles them.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", int'(out_valid), 0);
        chk("in_ready_after", int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        n_chk = 0;
        n_err = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;

`ifdef DIV_SIGNED_EN
        vecs[0] = '{8'h9C, 8'd7,   8'hF2, 8'hFE, 1'b0, LAT};
        vecs[1] = '{8'd5,  8'd0,   8'd0,  8'd0,  1'b1, 1};
        vecs[2] = '{8'h80, 8'hFF,  8'h80, 8'h00, 1'b0, LAT};
        vecs[3] = '{8'd100, 8'd7,  8'd14, 8'd2,  1'b0, LAT};
        vecs[4] = '{8'd100, 8'hF9, 8'hF2, 8'd2,  1'b0, LAT};
        vecs[5] = '{8'h9C, 8'hF9,  8'd14, 8'hFE, 1'b0, LAT};
        vecs[6] = '{8'h7F, 8'd1,   8'h7F, 8'd0,  1'b0, LAT};
        vecs[7] = '{8'd3,  8'h80,  8'd0,  8'd3,  1'b0, LAT};
`else
        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, LAT};
        vecs[1] = '{8'd5,   8'd0,   8'd0,   8'd0,   1'b1, 1};
        vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, LAT};
        vecs[3] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, LAT};
        vecs[4] = '{8'd7,   8'd200, 8'd0,   8'd7,   1'b0, LAT};
        vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, LAT};
        vecs[6] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, LAT};
        vecs[7] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0, LAT};
`endif

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_div_zero", int'(div_zero), 0);

        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].b);
            chk("busy_after_accept", int'(busy), 1);
            wait_valid(lat);
            chk("latency", lat, vecs[i].lat);
            chk("quotient", int'(quotient), int'(vecs[i].q));
            chk("remainder", int'(remainder), int'(vecs[i].r));
            chk("div_zero", int'(div_zero), int'(vecs[i].dz));
            chk("in_ready_done", int'(in_ready), 0);
            release_out();
        end

        // Backpressure: result must hold while a stray in_valid is ignored.
        accept(8'd100, 8'd9);
        wait_valid(lat);
        chk("hold_latency", lat, LAT);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (c == 2);
            dividend = 8'd50;
            divisor  = 8'd5;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_quotient", int'(quotient), 11);
            chk("hold_remainder", int'(remainder), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        release_out();
        repeat (3) @(posedge clk);
        #1;
        chk("no_queued_op", int'(busy), 0);

        // Asynchronous reset in the middle of CALC discards the operation.
        accept(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        @(negedge clk);
        rst = 1'b0;
        accept(8'd77, 8'd3);
        wait_valid(lat);
        chk("post_rst_latency", lat, LAT);
        chk("post_rst_quotient", int'(quotient), 25);
        chk("post_rst_remainder", int'(remainder), 2);
        release_out();

        // Back-to-back: second accept on the edge right after the handshake.
        accept(8'd60, 8'd7);
        wait_valid(lat);
        chk("b2b1_quotient", int'(quotient), 8);
        chk("b2b1_remainder", int'(remainder), 4);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 8'd121;
        divisor   = 8'd3;
        @(posedge clk);
        #1;
        chk("b2b_handshake_valid", int'(out_valid), 0);
        chk("b2b_handshake_ready", int'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'hAA;
        divisor  = 8'h55;
        chk("b2b_accepted", int'(busy), 1);
        wait_valid(lat);
        chk("b2b2_latency", lat, LAT);
        chk("b2b2_quotient", int'(quotient), 40);
        chk("b2b2_remainder", int'(remainder), 1);
        release_out();
        repeat (W + 3) @(posedge clk);
        #1;
        chk("b2b_no_duplicate", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
